// File: rtl/odd_even_sort_seq_pkg.sv
// Shared definitions for the sequential odd-even transposition sorter:
// FSM state encoding, phase-counter width helper and element packing.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Phase counter must hold the value DIM after the last phase.
  function automatic int unsigned cnt_width(input int unsigned dim);
    return $clog2(dim + 1);
  endfunction

  // Element i of a packed vector starts at bit i*width.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned width);
    return i * width;
  endfunction

endpackage

// File: rtl/odd_even_sort_seq_if.sv
// Valid/ready stream bundle for the sorter: input vector, output vector, busy.
interface odd_even_sort_seq_if #(
  parameter int unsigned DIM   = 4,
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_desc;
  logic [DIM*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIM*WIDTH-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_desc, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_desc, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/odd_even_sort_seq_cmp_swap.sv
// Combinational compare-exchange of one element pair; swaps only when the
// pair is strictly out of order, so equal elements keep their order.
module cmp_swap #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);
  logic gt;
  logic lt;

  // Order test and conditional exchange
  always_comb begin
    if (SIGNED) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    swap = desc ? lt : gt;
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/odd_even_sort_seq.sv
// Sequential odd-even transposition sorter: accepts a packed vector, runs
// DIM compare-exchange phases (one per clock), then presents the result.
module odd_even_sort_seq
  import sort_pkg::*;
#(
  parameter int unsigned DIM    = 4,
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  odd_even_sort_seq_if.slave bus
);
  localparam int unsigned CW = cnt_width(DIM);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    phase;
  logic             desc;
  logic [WIDTH-1:0] elem [DIM];
  logic [WIDTH-1:0] nxt  [DIM];
  logic [WIDTH-1:0] lo   [DIM-1];
  logic [WIDTH-1:0] hi   [DIM-1];
  logic [DIM-2:0]   sw;
  logic [DIM-2:0]   swap_vec;

  // One comparator per element boundary; even boundaries serve even phases,
  // odd boundaries serve odd phases.
  for (genvar k = 0; k < DIM - 1; k++) begin : g_bnd
    if (k % 2 == 0) begin : g_even
      cmp_swap #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cs (
        .a(elem[k]), .b(elem[k+1]), .desc(desc),
        .lo(lo[k]), .hi(hi[k]), .swap(sw[k])
      );
    end else begin : g_odd
      cmp_swap #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cs (
        .a(elem[k]), .b(elem[k+1]), .desc(desc),
        .lo(lo[k]), .hi(hi[k]), .swap(sw[k])
      );
    end
  end

  // Next element values for the current phase parity; swap_vec flags the
  // boundaries actually exchanging this cycle.
  always_comb begin
    for (int unsigned i = 0; i < DIM; i++) nxt[i] = elem[i];
    swap_vec = '0;
    for (int unsigned k = 0; k < DIM - 1; k++) begin
      if (k[0] == phase[0]) begin
        nxt[k]      = lo[k];
        nxt[k+1]    = hi[k];
        swap_vec[k] = (state == SORT) && sw[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = SORT;
      SORT:    if (phase == CW'(DIM - 1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Element array, direction latch and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      desc  <= 1'b0;
      for (int unsigned i = 0; i < DIM; i++) elem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          for (int unsigned i = 0; i < DIM; i++)
            elem[i] <= bus.in_data[elem_lsb(i, WIDTH) +: WIDTH];
          desc  <= bus.in_desc;
          phase <= '0;
        end
        SORT: begin
          for (int unsigned i = 0; i < DIM; i++) elem[i] <= nxt[i];
          phase <= phase + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs and result packing
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == SORT) || (state == DONE);
    bus.out_data  = '0;
    for (int unsigned i = 0; i < DIM; i++)
      bus.out_data[elem_lsb(i, WIDTH) +: WIDTH] = elem[i];
  end
endmodule
